mux_8_32: RTL
=============

// Module: mux_8_32
// PURPOSE
//  Byte-to-word packer on the clk_4f side of the PHY datapath; inverse of the 32->8 demux.
//  Collects four consecutive valid bytes, most-significant byte first, into one 32-bit word.
//  Presents that word, held stable, for one clk_f period (4 clk_4f cycles) to the clk_f-side logic.
//  Partial words caused by valid dropping mid-word are discarded, never emitted.
// PARAMETERS
//  BYTE_W   8   width of input lane
//  LANES    4   bytes per word; WORD_W = BYTE_W*LANES = 32
// PORTS
//  clk_4f     in   1       sole clock; all state updates on posedge
//  reset      in   1       asynchronous, active-low; 0 clears all state immediately
//  data_in    in   8       byte stream, sampled when valid=1
//  valid      in   1       qualifies data_in for the current cycle
//  data_out   out  32      packed word {b0,b1,b2,b3}, b0 = first byte received
//  valid_out  out  1       data_out holds a complete word
//  drop_cnt   out  8       partial words discarded (only with MUX_8_32_DROP_CNT_EN)
// BEHAVIOUR
//  Reset (reset=0): data_out=0, valid_out=0, byte index=0, hold count=0, state=IDLE, drop_cnt=0.
//  Input FSM (2 states, 2-bit byte index idx):
//   IDLE:    valid=1 -> store byte at lane 0, idx=1, go to COLLECT; valid=0 -> stay.
//   COLLECT: valid=1, idx<3 -> store byte at lane idx, idx++.
//            valid=1, idx=3 -> word complete: data_out <= {acc[31:8],data_in}, idx=0, stay in COLLECT.
//            valid=0 -> partial word discarded, idx=0, go to IDLE, drop event.
//  A new word starts on the cycle right after completion; back-to-back words need no gap.
//  Lane order: byte k lands in data_out[31-8k -: 8].
//  Latency: word visible on data_out/valid_out after the same edge that samples byte 3 (1 cycle).
//  Output hold: on completion, hold counter=3 and valid_out=1.
//   Each later cycle with no completion decrements the counter.
//   If the counter is 0 and no completion occurs, valid_out=0.
//   data_out is never cleared outside reset; it keeps the last word.
//  Continuous stream: completions every 4 cycles, so valid_out stays 1 and data_out changes every 4 cycles.
//  Simultaneous events:
//   A completion on the cycle the counter would expire reloads the counter (valid_out stays 1).
//   A drop during the hold window does not disturb data_out or valid_out already presented.
//  Accumulator lanes for the unfinished word are not cleared on drop; they are overwritten.
//  Reset mid-word: the accumulated bytes are lost; the first valid byte after release is lane 0.
// CONFIGURATION
//  MUX_8_32_DROP_CNT_EN defined:
//   drop_cnt port exists; increments on each COLLECT->IDLE transition with idx!=0.
//   Saturates at 255; cleared only by reset.
//  Undefined: port and counter absent; drops are silent. Datapath behaviour is identical.
// STRUCTURE
//  Shared header phy_defs.vh: BYTE_W, LANES, WORD_W, state encodings ST_IDLE=1'b0, ST_COLLECT=1'b1.
//  The same header is used by the 32->8 demux.
//  Sub-module mux_8_32_acc: lane accumulator (byte write-enable by idx, returns packed word).
//  Top level holds the FSM, the output hold counter and the optional drop counter.
//  The design must synthesize with the team cmos cell library.
//  Behavioural and synthesized netlists are compared cycle-by-cycle in the bench.
// TESTING
//  1 Reset: reset=0 with valid=1 and data_in=8'hFF -> data_out=0, valid_out=0; async clear mid-cycle.
//  2 Single word: valid=1 for bytes A1,B2,C3,D4 -> after 4th edge data_out=32'hA1B2C3D4, valid_out=1.
//    Then 4 idle cycles -> valid_out=0 and data_out held.
//  3 Stream: 8 bytes 01..08 back-to-back -> 32'h01020304, then 32'h05060708 4 cycles later; valid_out never drops.
//  4 Drop: bytes 11,22 then valid=0, then 33,44,55,66 -> only 32'h33445566 emitted; drop_cnt=1 if enabled.
//  5 Reset mid-word: bytes AA,BB, reset pulse, then 01,02,03,04 -> data_out=32'h01020304, no AA/BB leakage.
//  6 Loopback: demux_32_8 output into mux_8_32 with random 32-bit words.
//    Every input word is recovered unchanged; behavioural and cmos-synthesized models match every cycle.

Source files
------------

// File: rtl/mux_8_32_pkg.sv
// Shared widths and state encoding for the byte-to-word packer.
// Optional drop counter is enabled by defining MUX_8_32_DROP_CNT_EN.
package mux_8_32_pkg;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = BYTE_W * LANES;
  localparam int IDX_W  = 2;
  localparam int HEAD_W = WORD_W - BYTE_W;

  localparam logic [1:0] HOLD_INIT = 2'd3;
  localparam logic [7:0] DROP_MAX  = 8'hFF;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;
endpackage

// File: rtl/mux_8_32_acc.sv
// Lane accumulator: holds the first three bytes of the word being built.
// The final byte is merged directly by the top level on completion.
module mux_8_32_acc
  import mux_8_32_pkg::*;
(
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [HEAD_W-1:0] head
);

  logic [HEAD_W-1:0] acc_q;

  // Lane k sits at the MSB end, so byte 0 ends up in the top byte of the word.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      for (int k = 0; k < LANES - 1; k++) begin
        if (we && (idx == IDX_W'(k))) begin
          acc_q[HEAD_W-1-BYTE_W*k -: BYTE_W] <= byte_in;
        end
      end
    end
  end

  assign head = acc_q;

endmodule

// File: rtl/mux_8_32.sv
// Packs four consecutive valid bytes (MSB first) into a 32-bit word held for 4 cycles.
// Define MUX_8_32_DROP_CNT_EN to add the saturating drop_cnt output.
module mux_8_32
  import mux_8_32_pkg::*;
(
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
`ifdef MUX_8_32_DROP_CNT_EN
  output logic [7:0]        drop_cnt,
`endif
  output state_t            state_dbg
);

  // Handshake: data_in is consumed on every posedge where valid=1; there is no
  // backpressure. valid_out=1 means data_out holds a complete word.

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        hold_q;
  logic              acc_we;
  logic              complete;
  logic [HEAD_W-1:0] head;

  mux_8_32_acc u_acc (
    .clk_4f  (clk_4f),
    .reset   (reset),
    .we      (acc_we),
    .idx     (idx_q),
    .byte_in (data_in),
    .head    (head)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_we   = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          acc_we  = 1'b1;
          idx_d   = IDX_W'(1);
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (valid) begin
          if (idx_q == LAST_IDX) begin
            complete = 1'b1;
            idx_d    = '0;
          end else begin
            acc_we = 1'b1;
            idx_d  = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // A completion always reloads the hold window, so a steady stream never lets valid_out fall.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      hold_q    <= '0;
    end else if (complete) begin
      data_out  <= {head, data_in};
      valid_out <= 1'b1;
      hold_q    <= HOLD_INIT;
    end else if (hold_q != '0) begin
      hold_q <= hold_q - 2'd1;
    end else begin
      valid_out <= 1'b0;
    end
  end

`ifdef MUX_8_32_DROP_CNT_EN
  logic drop_evt;
  assign drop_evt = (state_q == ST_COLLECT) && !valid && (idx_q != '0);

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (drop_evt && (drop_cnt != DROP_MAX)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

  assign state_dbg = state_q;

endmodule
